// File: rtl/dma_pkg.sv
// Shared types and default widths for the DMA copy/fill engine.
package dma_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } dma_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 7;
endpackage

// File: rtl/dma_copy_engine.sv
// Single-port DMA engine: forward word copy (read/write alternating) or constant fill.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_abus,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    dma_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic [ADDR_W-1:0] idx_ext;
    logic [LEN_W-1:0]  idx_nxt;

    // Address offsets wrap naturally in ADDR_W-bit arithmetic.
    assign idx_ext = ADDR_W'(idx_q);
    assign idx_nxt = idx_q + LEN_W'(1);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        fill_d    = fill_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_abus  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    fill_d = fill_val;
                    idx_d  = '0;
                    if (len == '0)               state_d = S_DONE;
                    else if (mode == MODE_FILL)  state_d = S_WR;
                    else                         state_d = S_RD;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_abus = src_q + idx_ext;
                hold_d   = mem_rdata;
                state_d  = S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_abus  = dst_q + idx_ext;
                mem_wdata = (mode_q == MODE_FILL) ? fill_q : hold_q;
                idx_d     = idx_nxt;
                if (idx_nxt == len_q)          state_d = S_DONE;
                else if (mode_q == MODE_FILL)  state_d = S_WR;
                else                           state_d = S_RD;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end
endmodule
